// File: rtl/cache_level_responder_pkg.sv
// Shared types and address-field helpers for the direct-mapped cache level.
// Field helpers work on a 32-bit widened address; callers size-cast the result.
package cache_pkg;

    localparam int DEF_ADDR_W     = 15;
    localparam int DEF_INDEX_BITS = 4;
    localparam int DEF_OFF_BITS   = 2;
    localparam int DEF_DATA_W     = 32;
    localparam int DEF_TAG_W      = DEF_ADDR_W - DEF_INDEX_BITS - DEF_OFF_BITS;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        FILL_REQ,
        FILL_GAP,
        RESPOND,
        WAIT_LOW
    } state_t;

    function automatic logic [31:0] get_tag(input logic [31:0] a,
                                            input int index_bits,
                                            input int off_bits);
        return a >> (index_bits + off_bits);
    endfunction

    function automatic logic [31:0] get_index(input logic [31:0] a,
                                              input int index_bits,
                                              input int off_bits);
        return (a >> off_bits) & ((32'd1 << index_bits) - 32'd1);
    endfunction

    function automatic logic [31:0] get_offset(input logic [31:0] a,
                                               input int off_bits);
        return a & ((32'd1 << off_bits) - 32'd1);
    endfunction

endpackage

// File: rtl/cache_level_responder_if.sv
// Request protocol bundle: upstream addr/enable/requestComplete/dataOut plus
// the identical downstream protocol toward the next level or main memory.
interface cache_level_responder_if #(
    parameter int ADDR_W = 15,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] addr;
    logic              enable;
    logic              requestComplete;
    logic [DATA_W-1:0] dataOut;
    logic [ADDR_W-1:0] memAddr;
    logic              memEnable;
    logic              memComplete;
    logic [DATA_W-1:0] memData;

    modport slave (
        input  addr, enable, memComplete, memData,
        output requestComplete, dataOut, memAddr, memEnable
    );

    modport master (
        output addr, enable, memComplete, memData,
        input  requestComplete, dataOut, memAddr, memEnable
    );
endinterface

// File: rtl/cache_level_responder_line_array.sv
// Valid/tag/data storage for the cache: one synchronous write port, a
// combinational read of the indexed line, and valid bits cleared on reset.
module cache_line_array
    import cache_pkg::*;
#(
    parameter int INDEX_BITS = 4,
    parameter int OFF_BITS   = 2,
    parameter int TAG_W      = 9,
    parameter int DATA_W     = 32
) (
    input  logic                                    clock,
    input  logic                                    reset,
    input  logic [INDEX_BITS-1:0]                   rd_index,
    output logic                                    rd_valid,
    output logic [TAG_W-1:0]                        rd_tag,
    output logic [(1<<OFF_BITS)-1:0][DATA_W-1:0]    rd_words,
    input  logic [INDEX_BITS-1:0]                   wr_index,
    input  logic                                    wr_en,
    input  logic [OFF_BITS-1:0]                     wr_word,
    input  logic [DATA_W-1:0]                       wr_data,
    input  logic                                    set_valid,
    input  logic [TAG_W-1:0]                        set_tag
);
    localparam int LINES = 1 << INDEX_BITS;
    localparam int WORDS = 1 << OFF_BITS;

    logic [LINES-1:0]                 valid;
    logic [TAG_W-1:0]                 tags  [LINES];
    logic [WORDS-1:0][DATA_W-1:0]     lines [LINES];

    always_ff @(posedge clock) begin
        if (reset) begin
            valid <= '0;
        end else if (set_valid) begin
            valid[wr_index] <= 1'b1;
        end
    end

    // Tag and data need no reset: a line is only trusted once its valid bit is set.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            lines[wr_index][wr_word] <= wr_data;
        end
        if (set_valid) begin
            tags[wr_index] <= set_tag;
        end
    end

    assign rd_valid = valid[rd_index];
    assign rd_tag   = tags[rd_index];
    assign rd_words = lines[rd_index];

endmodule

// File: rtl/cache_level_responder.sv
// One direct-mapped, read-only cache level: responder upstream, initiator
// downstream, filling a whole block one word access at a time on a miss.
module cache_level_responder
    import cache_pkg::*;
#(
    parameter int ADDR_W     = 15,
    parameter int INDEX_BITS = 4,
    parameter int OFF_BITS   = 2,
    parameter int HIT_DELAY  = 1,
    parameter int DATA_W     = 32
) (
    input  logic                     clock,
    input  logic                     reset,
    cache_level_responder_if.slave   bus
);
    localparam int TAG_W = ADDR_W - INDEX_BITS - OFF_BITS;
    localparam int WORDS = 1 << OFF_BITS;
    localparam int CNT_W = $clog2(HIT_DELAY + 1);

    state_t                           state, state_next;
    logic [ADDR_W-1:0]                req_addr, req_addr_next;
    logic [OFF_BITS-1:0]              word, word_next;
    logic [CNT_W-1:0]                 cnt, cnt_next;
    logic [DATA_W-1:0]                data_q, data_next;

    logic [TAG_W-1:0]                 req_tag;
    logic [INDEX_BITS-1:0]            req_index;
    logic [OFF_BITS-1:0]              req_off;
    logic                             rd_valid;
    logic [TAG_W-1:0]                 rd_tag;
    logic [WORDS-1:0][DATA_W-1:0]     rd_words;
    logic                             hit;
    logic                             wr_en;
    logic                             set_valid;

    assign req_tag   = TAG_W'(get_tag(32'(req_addr), INDEX_BITS, OFF_BITS));
    assign req_index = INDEX_BITS'(get_index(32'(req_addr), INDEX_BITS, OFF_BITS));
    assign req_off   = OFF_BITS'(get_offset(32'(req_addr), OFF_BITS));
    assign hit       = rd_valid && (rd_tag == req_tag);

    cache_line_array #(
        .INDEX_BITS (INDEX_BITS),
        .OFF_BITS   (OFF_BITS),
        .TAG_W      (TAG_W),
        .DATA_W     (DATA_W)
    ) u_lines (
        .clock     (clock),
        .reset     (reset),
        .rd_index  (req_index),
        .rd_valid  (rd_valid),
        .rd_tag    (rd_tag),
        .rd_words  (rd_words),
        .wr_index  (req_index),
        .wr_en     (wr_en),
        .wr_word   (word),
        .wr_data   (bus.memData),
        .set_valid (set_valid),
        .set_tag   (req_tag)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            req_addr <= '0;
            word     <= '0;
            cnt      <= '0;
            data_q   <= '0;
        end else begin
            state    <= state_next;
            req_addr <= req_addr_next;
            word     <= word_next;
            cnt      <= cnt_next;
            data_q   <= data_next;
        end
    end

    // The final fill word lands in the array one edge before FILL_GAP reads the line back.
    always_comb begin
        state_next    = state;
        req_addr_next = req_addr;
        word_next     = word;
        cnt_next      = cnt;
        data_next     = data_q;
        wr_en         = 1'b0;
        set_valid     = 1'b0;
        case (state)
            IDLE: begin
                if (bus.enable) begin
                    req_addr_next = bus.addr;
                    cnt_next      = CNT_W'(HIT_DELAY - 1);
                    state_next    = LOOKUP;
                end
            end
            LOOKUP: begin
                if (cnt != '0) begin
                    cnt_next = cnt - 1'b1;
                end else if (hit) begin
                    data_next  = rd_words[req_off];
                    state_next = RESPOND;
                end else begin
                    word_next  = '0;
                    state_next = FILL_REQ;
                end
            end
            FILL_REQ: begin
                if (bus.memComplete) begin
                    wr_en      = 1'b1;
                    state_next = FILL_GAP;
                end
            end
            FILL_GAP: begin
                if (word == OFF_BITS'(WORDS - 1)) begin
                    set_valid  = 1'b1;
                    data_next  = rd_words[req_off];
                    state_next = RESPOND;
                end else begin
                    word_next  = word + 1'b1;
                    state_next = FILL_REQ;
                end
            end
            RESPOND: begin
                state_next = WAIT_LOW;
            end
            WAIT_LOW: begin
                if (!bus.enable) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign bus.requestComplete = (state == RESPOND);
    assign bus.memEnable       = (state == FILL_REQ);
    assign bus.memAddr         = {req_addr[ADDR_W-1:OFF_BITS], word};
    assign bus.dataOut         = data_q;

endmodule
